// File: rtl/mem_fetch_engine.sv
// Band fetch engine: on each fetch_run_i pulse, reads the next ROWS_PER_FETCH image rows from BRAM
// and streams them in raster order over valid/ready, then pulses fetch_done_o.
module mem_fetch_engine #(
   parameter int MAX_ROW        = 540,
   parameter int MAX_COL        = 540,
   parameter int ROWS_PER_FETCH = 1,
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 19,
   parameter int RD_LAT         = 1,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_run_i,
   output logic              fetch_done_o,
   output logic              frame_done_o,
   output logic              busy_o,
   output logic              bram_en_o,
   output logic [ADDR_W-1:0] bram_addr_o,
   input  logic [DATA_W-1:0] bram_rdata_i,
   output logic              buf_valid_o,
   input  logic              buf_ready_i,
   output logic [DATA_W-1:0] buf_data_o,
   output logic [9:0]        buf_row_o,
   output logic [9:0]        buf_col_o
);

   localparam int IF_W  = $clog2(RD_LAT + 1) + 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

   state_e state_q, state_d;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [9:0]        row_q, row_d;
   logic [9:0]        col_q, col_d;
   logic [9:0]        band_q, band_d;
   logic [IF_W-1:0]   inflight_q, inflight_d;
   logic [RD_LAT-1:0] vld_pipe_q;
   logic [9:0]        row_pipe_q [RD_LAT];
   logic [9:0]        col_pipe_q [RD_LAT];

   logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
   logic [9:0]        row_mem_q  [FIFO_DEPTH];
   logic [9:0]        col_mem_q  [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

   logic issue, ret, push, pop;
   logic last_col, last_addr, frame_end;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit counts both queued beats and reads still in the BRAM pipe, so a return always has a slot.
   assign issue     = (state_q == S_READ) && ((int'(fifo_cnt_q) + int'(inflight_q)) < FIFO_DEPTH);
   assign ret       = vld_pipe_q[RD_LAT-1];
   assign push      = ret;
   assign pop       = buf_valid_o && buf_ready_i;
   assign last_col  = (col_q == 10'(MAX_COL - 1));
   assign last_addr = last_col && (band_q == 10'(ROWS_PER_FETCH - 1));
   assign frame_end = (row_q == 10'(MAX_ROW));

   assign inflight_d = inflight_q + IF_W'(issue) - IF_W'(ret);
   assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (fetch_run_i) state_d = S_READ;
         S_READ:  if (issue && last_addr) state_d = S_DRAIN;
         // Look at next-cycle occupancy so done lands the cycle after the final handshake.
         S_DRAIN: if ((inflight_d == '0) && (fifo_cnt_d == '0)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy_o       = (state_q != S_IDLE);
      fetch_done_o = (state_q == S_DONE);
      frame_done_o = (state_q == S_DONE) && frame_end;
      bram_en_o    = issue;
      bram_addr_o  = addr_q;
   end

   // Read position: address increments alongside row/col; wraps only at end of frame.
   always_comb begin
      addr_d = addr_q;
      row_d  = row_q;
      col_d  = col_q;
      band_d = band_q;
      if (issue) begin
         addr_d = addr_q + ADDR_W'(1);
         if (last_col) begin
            col_d  = '0;
            row_d  = row_q + 10'd1;
            band_d = band_q + 10'd1;
         end else begin
            col_d  = col_q + 10'd1;
         end
      end
      if (state_q == S_DONE) begin
         band_d = '0;
         if (frame_end) begin
            row_d  = '0;
            addr_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         band_q     <= '0;
         inflight_q <= '0;
         vld_pipe_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         addr_q     <= addr_d;
         row_q      <= row_d;
         col_q      <= col_d;
         band_q     <= band_d;
         inflight_q <= inflight_d;
         vld_pipe_q[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   // NOTE: tag pipe and FIFO storage are not reset; only valid bits and pointers are, and outputs are gated by valid.
   always_ff @(posedge clk) begin
      row_pipe_q[0] <= row_q;
      col_pipe_q[0] <= col_q;
      for (int i = 1; i < RD_LAT; i++) begin
         row_pipe_q[i] <= row_pipe_q[i-1];
         col_pipe_q[i] <= col_pipe_q[i-1];
      end
      if (push) begin
         data_mem_q[wr_ptr_q] <= bram_rdata_i;
         row_mem_q[wr_ptr_q]  <= row_pipe_q[RD_LAT-1];
         col_mem_q[wr_ptr_q]  <= col_pipe_q[RD_LAT-1];
      end
   end

   assign buf_valid_o = (fifo_cnt_q != '0);
   assign buf_data_o  = buf_valid_o ? data_mem_q[rd_ptr_q] : '0;
   assign buf_row_o   = buf_valid_o ? row_mem_q[rd_ptr_q]  : '0;
   assign buf_col_o   = buf_valid_o ? col_mem_q[rd_ptr_q]  : '0;

endmodule

// File: tb/tb_mem_fetch_engine.sv
// Directed bench for mem_fetch_engine: instance A (RD_LAT=1, 1 row/band) and instance B
// (RD_LAT=2, 2 rows/band, random ready) on reduced frame sizes, each with a BRAM model and scoreboard.
module tb_mem_fetch_engine;

   localparam int A_ROWS = 6, A_COLS = 10, A_RPF = 1, A_LAT = 1;
   localparam int B_ROWS = 4, B_COLS = 6,  B_RPF = 2, B_LAT = 2;
   localparam int DW = 8, AW = 19, DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          a_run = 1'b0, a_ready = 1'b1;
   logic          a_done, a_frame, a_busy, a_en, a_valid;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_rdata = '0, a_data;
   logic [9:0]    a_row, a_col;

   logic          b_run = 1'b0, b_ready = 1'b1;
   logic          b_done, b_frame, b_busy, b_en, b_valid;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_s0 = '0, b_rdata = '0, b_data;
   logic [9:0]    b_row, b_col;

   int n_vec = 0, n_err = 0;

   mem_fetch_engine #(.MAX_ROW(A_ROWS), .MAX_COL(A_COLS), .ROWS_PER_FETCH(A_RPF), .DATA_W(DW),
                      .ADDR_W(AW), .RD_LAT(A_LAT), .FIFO_DEPTH(DEPTH)) dut_a (
      .clk(clk), .rst_n(rst_n), .fetch_run_i(a_run), .fetch_done_o(a_done), .frame_done_o(a_frame),
      .busy_o(a_busy), .bram_en_o(a_en), .bram_addr_o(a_addr), .bram_rdata_i(a_rdata),
      .buf_valid_o(a_valid), .buf_ready_i(a_ready), .buf_data_o(a_data), .buf_row_o(a_row),
      .buf_col_o(a_col));

   mem_fetch_engine #(.MAX_ROW(B_ROWS), .MAX_COL(B_COLS), .ROWS_PER_FETCH(B_RPF), .DATA_W(DW),
                      .ADDR_W(AW), .RD_LAT(B_LAT), .FIFO_DEPTH(DEPTH)) dut_b (
      .clk(clk), .rst_n(rst_n), .fetch_run_i(b_run), .fetch_done_o(b_done), .frame_done_o(b_frame),
      .busy_o(b_busy), .bram_en_o(b_en), .bram_addr_o(b_addr), .bram_rdata_i(b_rdata),
      .buf_valid_o(b_valid), .buf_ready_i(b_ready), .buf_data_o(b_data), .buf_row_o(b_row),
      .buf_col_o(b_col));

   function automatic logic [7:0] pix(input int addr);
      return 8'(addr * 37 + (addr >> 6) + 11);
   endfunction

   // BRAM models: A has one register stage, B two.
   always @(posedge clk) begin
      if (a_en) a_rdata <= pix(int'(a_addr));
      if (b_en) b_s0 <= pix(int'(b_addr));
      b_rdata <= b_s0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard A: read addresses and delivered beats in raster order.
   int a_exp_addr = 0, a_exp_row = 0, a_exp_col = 0, a_en_cnt = 0, a_beats = 0;
   always @(negedge clk) begin
      if (a_en) begin
         check("a_addr", 32'(a_addr), 32'(a_exp_addr));
         a_exp_addr = (a_exp_addr + 1 == A_ROWS * A_COLS) ? 0 : a_exp_addr + 1;
         a_en_cnt++;
      end
      if (a_valid && a_ready) begin
         check("a_data", 32'(a_data), 32'(pix(a_exp_row * A_COLS + a_exp_col)));
         check("a_row", 32'(a_row), 32'(a_exp_row));
         check("a_col", 32'(a_col), 32'(a_exp_col));
         a_beats++;
         a_exp_col++;
         if (a_exp_col == A_COLS) begin
            a_exp_col = 0;
            a_exp_row = (a_exp_row + 1 == A_ROWS) ? 0 : a_exp_row + 1;
         end
      end
      if (!rst_n) begin
         a_exp_addr = 0; a_exp_row = 0; a_exp_col = 0;
      end
   end

   // Scoreboard B: order, stall stability and credit limit.
   int b_exp_addr = 0, b_exp_row = 0, b_exp_col = 0, b_en_cnt = 0, b_beats = 0, b_out = 0;
   logic          b_stall = 1'b0;
   logic [DW-1:0] b_pdata = '0;
   logic [9:0]    b_prow = '0, b_pcol = '0;
   always @(negedge clk) begin
      if (b_stall) begin
         check("b_hold_valid", 32'(b_valid), 32'd1);
         check("b_hold_data", 32'(b_data), 32'(b_pdata));
         check("b_hold_row", 32'(b_row), 32'(b_prow));
         check("b_hold_col", 32'(b_col), 32'(b_pcol));
      end
      if (b_en) begin
         check("b_credit", 32'(b_out < DEPTH), 32'd1);
         check("b_addr", 32'(b_addr), 32'(b_exp_addr));
         b_exp_addr = (b_exp_addr + 1 == B_ROWS * B_COLS) ? 0 : b_exp_addr + 1;
         b_en_cnt++;
      end
      if (b_valid && b_ready) begin
         check("b_data", 32'(b_data), 32'(pix(b_exp_row * B_COLS + b_exp_col)));
         check("b_row", 32'(b_row), 32'(b_exp_row));
         check("b_col", 32'(b_col), 32'(b_exp_col));
         b_beats++;
         b_exp_col++;
         if (b_exp_col == B_COLS) begin
            b_exp_col = 0;
            b_exp_row = (b_exp_row + 1 == B_ROWS) ? 0 : b_exp_row + 1;
         end
      end
      b_out   = b_out + int'(b_en) - int'(b_valid && b_ready);
      b_stall = b_valid && !b_ready;
      b_pdata = b_data; b_prow = b_row; b_pcol = b_col;
      if (!rst_n) begin
         b_exp_addr = 0; b_exp_row = 0; b_exp_col = 0; b_out = 0; b_stall = 1'b0;
      end
   end

   // One band on A; ready held low for 'stall' cycles, run held for the whole fetch when 'hold'.
   task automatic fetch_a(input bit hold, input int stall, output int t_first, output int t_done,
                          output logic frame, output int en_stall);
      int t  = 0;
      int e0 = a_en_cnt;
      t_first = -1; t_done = -1; frame = 1'b0; en_stall = 0;
      a_run   = 1'b1;
      a_ready = (stall == 0);
      while (t_done < 0 && t < 1000) begin
         if (t == stall && stall > 0) begin
            a_ready  = 1'b1;
            en_stall = a_en_cnt - e0;
         end
         @(negedge clk);
         if (a_valid && t_first < 0) t_first = t;
         if (a_done) begin
            t_done = t;
            frame  = a_frame;
            a_run  = 1'b0;
         end
         @(posedge clk); #1;
         t++;
         if (!hold) a_run = 1'b0;
      end
      a_run = 1'b0; a_ready = 1'b1;
   endtask

   task automatic fetch_b(input bit rnd, output int t_first, output int t_done, output logic frame);
      int t = 0;
      t_first = -1; t_done = -1; frame = 1'b0;
      b_run = 1'b1; b_ready = 1'b1;
      while (t_done < 0 && t < 1000) begin
         @(negedge clk);
         if (b_valid && t_first < 0) t_first = t;
         if (b_done) begin
            t_done = t;
            frame  = b_frame;
         end
         @(posedge clk); #1;
         t++;
         b_run   = 1'b0;
         b_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      b_ready = 1'b1;
   endtask

   task automatic check_a_zero(input string tag);
      check({tag, "_busy"},  32'(a_busy),  32'd0);
      check({tag, "_done"},  32'(a_done),  32'd0);
      check({tag, "_frame"}, 32'(a_frame), 32'd0);
      check({tag, "_en"},    32'(a_en),    32'd0);
      check({tag, "_addr"},  32'(a_addr),  32'd0);
      check({tag, "_valid"}, 32'(a_valid), 32'd0);
      check({tag, "_data"},  32'(a_data),  32'd0);
      check({tag, "_row"},   32'(a_row),   32'd0);
      check({tag, "_col"},   32'(a_col),   32'd0);
   endtask

   initial begin
      int   tf, td, es, b0, e0, guard;
      logic fr;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_a_zero("rst");
      check("rst_b_busy", 32'(b_busy), 32'd0);
      check("rst_b_valid", 32'(b_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Whole frame plus one wrap: first beat at 3, done at N+3, frame flag on last band only
      for (int k = 0; k <= A_ROWS; k++) begin
         b0 = a_beats; e0 = a_en_cnt;
         fetch_a(1'b0, 0, tf, td, fr, es);
         check("a_first", 32'(tf), 32'd3);
         check("a_done_t", 32'(td), 32'(A_COLS * A_RPF + 3));
         check("a_frame_flag", 32'(fr), 32'(k == A_ROWS - 1));
         check("a_beats", 32'(a_beats - b0), 32'(A_COLS * A_RPF));
         check("a_reads", 32'(a_en_cnt - e0), 32'(A_COLS * A_RPF));
         repeat (2) @(posedge clk);
         #1;
      end

      // Run held high through a fetch: one band only, then a pulse starts the following row
      b0 = a_beats; e0 = a_en_cnt;
      fetch_a(1'b1, 0, tf, td, fr, es);
      check("hold_done_t", 32'(td), 32'(A_COLS * A_RPF + 3));
      repeat (4) @(posedge clk);
      #1;
      check("hold_reads", 32'(a_en_cnt - e0), 32'(A_COLS * A_RPF));
      check("hold_beats", 32'(a_beats - b0), 32'(A_COLS * A_RPF));
      check("hold_idle", 32'(a_busy), 32'd0);
      fetch_a(1'b0, 0, tf, td, fr, es);
      check("repulse_done_t", 32'(td), 32'(A_COLS * A_RPF + 3));

      // Ready low for 100 cycles: reads stop at FIFO depth, then one beat per cycle
      fetch_a(1'b0, 100, tf, td, fr, es);
      check("stall_reads", 32'(es), 32'(DEPTH));
      check("stall_done_t", 32'(td), 32'(100 + A_COLS * A_RPF));

      // Reset mid-band after 5 beats
      b0 = a_beats; guard = 0;
      a_run = 1'b1;
      @(posedge clk); #1;
      a_run = 1'b0;
      while (a_beats - b0 < 5 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("midband_beats", 32'(a_beats - b0), 32'd5);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_a_zero("abort");
      @(posedge clk); #1;
      fetch_a(1'b0, 0, tf, td, fr, es);
      check("post_rst_done_t", 32'(td), 32'(A_COLS * A_RPF + 3));
      check("post_rst_frame", 32'(fr), 32'd0);

      // Instance B: nominal timing, then random ready across a frame wrap
      for (int k = 0; k < 4; k++) begin
         b0 = b_beats; e0 = b_en_cnt;
         fetch_b(k != 0, tf, td, fr);
         if (k == 0) begin
            check("b_first", 32'(tf), 32'(2 + B_LAT));
            check("b_done_t", 32'(td), 32'(B_COLS * B_RPF + 2 + B_LAT));
         end else begin
            check("b_done_seen", 32'(td >= 0), 32'd1);
         end
         check("b_frame_flag", 32'(fr), 32'(k % 2 == 1));
         check("b_beats", 32'(b_beats - b0), 32'(B_COLS * B_RPF));
         check("b_reads", 32'(b_en_cnt - e0), 32'(B_COLS * B_RPF));
         repeat (2) @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
